// File: rtl/enc_sched_pkg.sv
// Shared types and constants for the encryption-core scheduler.
// Struct widths follow ENC_N / ENC_IDW; override the top's N / IDW only together with these.
package enc_sched_pkg;

    localparam int LATENCY = 5;
    localparam int ENC_N   = 8;
    localparam int ENC_IDW = 2;

    typedef struct packed {
        logic               valid;
        logic [ENC_IDW-1:0] id;
    } tag_t;

    typedef struct packed {
        logic [ENC_IDW-1:0] id;
        logic [ENC_N-1:0]   data;
    } fifo_entry_t;

    // Round-robin successor of v among r requesters.
    function automatic logic [ENC_IDW-1:0] wrap_inc(input logic [ENC_IDW-1:0] v,
                                                    input int unsigned        r);
        return (32'(v) == r - 1) ? '0 : v + 1'b1;
    endfunction

endpackage

// File: rtl/enc_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after i_ptr wins.
// o_grant is one-hot when i_enable is set and someone requests, otherwise zero.
module enc_rr_arbiter #(
    parameter int R   = 4,
    parameter int IDW = 2
) (
    input  logic [R-1:0]   i_req,
    input  logic [IDW-1:0] i_ptr,
    input  logic           i_enable,
    output logic [R-1:0]   o_grant,
    output logic [IDW-1:0] o_grant_idx
);

    logic w_found;

    always_comb begin
        // NOTE: every output gets a default first, so no path through the loop infers a latch.
        w_found     = 1'b0;
        o_grant_idx = '0;
        o_grant     = '0;
        for (int k = 0; k < R; k++) begin
            if (!w_found && i_req[(int'(i_ptr) + k) % R]) begin
                w_found     = 1'b1;
                o_grant_idx = IDW'((int'(i_ptr) + k) % R);
            end
        end
        for (int k = 0; k < R; k++) begin
            o_grant[k] = w_found && i_enable && (o_grant_idx == IDW'(k));
        end
    end

endmodule

// File: rtl/encryption.sv
// Five-stage non-stallable encryption core: e_data = ~rotl1(data ^ key), five cycles later.
// Data registers carry no reset; the scheduler's tag pipeline marks which stages hold real beats.
module encryption #(
    parameter int N = 8
) (
    input  logic         clock,
    input  logic [N-1:0] data,
    input  logic [N-1:0] key,
    output logic [N-1:0] e_data
);

    logic [N-1:0] r_s1;
    logic [N-1:0] r_s2;
    logic [N-1:0] r_s3;
    logic [N-1:0] r_s4;
    logic [N-1:0] r_s5;

    // NOTE: non-blocking assignments, so every stage samples its predecessor's pre-edge value.
    always_ff @(posedge clock) begin
        r_s1 <= data ^ key;
        r_s2 <= {r_s1[N-2:0], r_s1[N-1]};
        r_s3 <= ~r_s2;
        r_s4 <= r_s3;
        r_s5 <= r_s4;
    end

    assign e_data = r_s5;

endmodule

// File: rtl/enc_pipe_scheduler.sv
// Shares one encryption core between R requesters with round-robin issue, per-requester keys,
// a tag pipeline tracking each beat's owner, and a credit-gated output FIFO.
module enc_pipe_scheduler
    import enc_sched_pkg::*;
#(
    parameter int N          = ENC_N,
    parameter int R          = 4,
    parameter int IDW        = ENC_IDW,
    parameter int FIFO_DEPTH = 8
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [R-1:0]   req_valid,
    input  logic [R*N-1:0] req_data,
    output logic [R-1:0]   req_ready,
    input  logic           cfg_we,
    input  logic [IDW-1:0] cfg_id,
    input  logic [N-1:0]   cfg_key,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   out_data,
    output logic [IDW-1:0] out_id,
    output logic           busy
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = CW + 1;

    logic [N-1:0]   r_key [R];
    logic [IDW-1:0] r_ptr;
    tag_t           r_tag [1:LATENCY];
    fifo_entry_t    r_mem [FIFO_DEPTH];
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;

    logic [SW-1:0]  w_inflight;
    logic [SW-1:0]  w_occupancy;
    logic           w_credit;
    logic [R-1:0]   w_grant;
    logic [IDW-1:0] w_grant_idx;
    logic           w_hs;
    logic [N-1:0]   w_core_data;
    logic [N-1:0]   w_core_key;
    logic [N-1:0]   w_e_data;
    logic           w_push;
    logic           w_pop;

    always_comb begin
        w_inflight = '0;
        for (int i = 1; i <= LATENCY; i++) begin
            w_inflight = w_inflight + SW'(r_tag[i].valid);
        end
    end

    // Beats already in the core hold a FIFO slot, so the non-stallable core can never overflow it.
    assign w_occupancy = SW'(r_count) + w_inflight;
    assign w_credit    = (w_occupancy < SW'(FIFO_DEPTH));

    enc_rr_arbiter #(
        .R   (R),
        .IDW (IDW)
    ) u_arb (
        .i_req       (req_valid),
        .i_ptr       (r_ptr),
        .i_enable    (w_credit & ~reset),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx)
    );

    assign req_ready   = w_grant;
    assign w_hs        = |w_grant;
    assign w_core_data = req_data[w_grant_idx*N +: N];
    assign w_core_key  = r_key[w_grant_idx];

    encryption #(
        .N (N)
    ) u_core (
        .clock  (clock),
        .data   (w_core_data),
        .key    (w_core_key),
        .e_data (w_e_data)
    );

    // A same-cycle grant reads the old key; the new one is visible from the next cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < R; i++) begin
                r_key[i] <= '0;
            end
        end else if (cfg_we) begin
            r_key[cfg_id] <= cfg_key;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (w_hs) begin
            r_ptr <= wrap_inc(w_grant_idx, R);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 1; i <= LATENCY; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            r_tag[1] <= '{valid: w_hs, id: w_grant_idx};
            for (int i = 2; i <= LATENCY; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    assign w_push = r_tag[LATENCY].valid;
    assign w_pop  = out_valid & out_ready;

    // NOTE: FIFO storage is not reset; only pointers and count are, and they decide what is valid.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= '{id: r_tag[LATENCY].id, data: w_e_data};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign out_valid = (r_count != '0) & ~reset;
    assign out_data  = r_mem[r_rd_ptr].data;
    assign out_id    = r_mem[r_rd_ptr].id;
    assign busy      = ((w_inflight != '0) | (r_count != '0)) & ~reset;

    a_no_overflow: assert property (@(posedge clock) disable iff (reset)
        !(w_push && r_count == CW'(FIFO_DEPTH)));

endmodule

// File: tb/tb_enc_pipe_scheduler.sv
// Directed bench for enc_pipe_scheduler; expected ciphertexts are ~rotl1(data ^ key), worked by hand.
module tb_enc_pipe_scheduler;

    localparam int N = 8;
    localparam int R = 4;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic [R-1:0]   req_valid = '0;
    logic [R*N-1:0] req_data = '0;
    logic [R-1:0]   req_ready;
    logic           cfg_we = 1'b0;
    logic [1:0]     cfg_id = '0;
    logic [N-1:0]   cfg_key = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [N-1:0]   out_data;
    logic [1:0]     out_id;
    logic           busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int         id;
        logic [7:0] data;
        int         cyc;
    } rec_t;

    rec_t q_out[$];
    rec_t q_hs[$];

    enc_pipe_scheduler #(
        .N          (N),
        .R          (R),
        .IDW        (2),
        .FIFO_DEPTH (8)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .cfg_we    (cfg_we),
        .cfg_id    (cfg_id),
        .cfg_key   (cfg_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        rec_t r;
        if (out_valid && out_ready) begin
            r.id = int'(out_id); r.data = out_data; r.cyc = cyc;
            q_out.push_back(r);
        end
        for (int i = 0; i < R; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                r.id = i; r.data = req_data[i*N +: N]; r.cyc = cyc;
                q_hs.push_back(r);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        @(negedge clock);
        while (busy !== 1'b0 && n < 60) begin
            @(negedge clock);
            n++;
        end
        check(tag, 32'(busy), 32'd0);
        next_cycle();
    endtask

    function automatic logic [31:0] out_data_at(input int i);
        return (i < q_out.size()) ? 32'(q_out[i].data) : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] out_id_at(input int i);
        return (i < q_out.size()) ? 32'(q_out[i].id) : 32'hDEAD_BEEF;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] exp_t3 [4];
        logic [7:0] exp_t4 [12];
        int t0;
        int hs;
        int n;
        exp_t3 = '{8'hFD, 8'hFB, 8'hFE, 8'h87};
        exp_t4 = '{8'hBF, 8'hBD, 8'hBB, 8'hB9, 8'hB7, 8'hB5, 8'hB3, 8'hB1,
                   8'hAF, 8'hAD, 8'hAB, 8'hA9};

        // Reset with every requester asking: nothing may be accepted or reported.
        reset = 1'b1;
        req_valid = 4'hF;
        next_cycle();
        @(negedge clock);
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        next_cycle();
        reset = 1'b0;
        req_valid = '0;
        @(negedge clock);
        check("post_rst_out_valid", 32'(out_valid), 32'h0);
        check("post_rst_busy", 32'(busy), 32'h0);
        next_cycle();

        // 1. Single beat: 0x01 with key 0 -> 0xFD, visible six cycles after the handshake.
        q_out.delete(); q_hs.delete();
        req_valid = 4'b0001;
        req_data[7:0] = 8'h01;
        @(negedge clock);
        check("t1_ready", 32'(req_ready), 32'h1);
        t0 = cyc;
        next_cycle();
        req_valid = '0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clock);
            check($sformatf("t1_no_out_t+%0d", k), 32'(out_valid), 32'h0);
            next_cycle();
        end
        @(negedge clock);
        check("t1_latency", 32'(cyc - t0), 32'd6);
        check("t1_out_valid", 32'(out_valid), 32'h1);
        check("t1_out_data", 32'(out_data), 32'hFD);
        check("t1_out_id", 32'(out_id), 32'h0);
        check("t1_busy_hold", 32'(busy), 32'h1);
        next_cycle();
        @(negedge clock);
        check("t1_busy_drop", 32'(busy), 32'h0);
        check("t1_out_valid_drop", 32'(out_valid), 32'h0);
        next_cycle();

        // 2. Key effect on requester 1.
        q_out.delete(); q_hs.delete();
        cfg_we = 1'b1; cfg_id = 2'd1; cfg_key = 8'hFF;
        next_cycle();
        cfg_we = 1'b0;
        req_valid = 4'b0010; req_data[15:8] = 8'h00;
        @(negedge clock);
        check("t2_ready_a", 32'(req_ready), 32'h2);
        next_cycle();
        req_valid = '0;
        cfg_we = 1'b1; cfg_id = 2'd1; cfg_key = 8'h00;
        next_cycle();
        cfg_we = 1'b0;
        req_valid = 4'b0010;
        @(negedge clock);
        check("t2_ready_b", 32'(req_ready), 32'h2);
        next_cycle();
        req_valid = '0;
        wait_idle("t2_idle");
        check("t2_count", 32'(q_out.size()), 32'd2);
        check("t2_data0", out_data_at(0), 32'h00);
        check("t2_id0", out_id_at(0), 32'd1);
        check("t2_data1", out_data_at(1), 32'hFF);
        check("t2_id1", out_id_at(1), 32'd1);

        // 5. Key write colliding with a grant to the same requester.
        q_out.delete(); q_hs.delete();
        cfg_we = 1'b1; cfg_id = 2'd2; cfg_key = 8'hFF;
        req_valid = 4'b0100; req_data[23:16] = 8'h00;
        @(negedge clock);
        check("t5_ready_a", 32'(req_ready), 32'h4);
        next_cycle();
        cfg_we = 1'b0;
        @(negedge clock);
        check("t5_ready_b", 32'(req_ready), 32'h4);
        next_cycle();
        req_valid = '0;
        wait_idle("t5_idle");
        check("t5_count", 32'(q_out.size()), 32'd2);
        check("t5_data0", out_data_at(0), 32'hFF);
        check("t5_data1", out_data_at(1), 32'h00);
        check("t5_id1", out_id_at(1), 32'd2);

        // 6. Reset with three beats in flight.
        q_out.delete(); q_hs.delete();
        req_valid = 4'b0001; req_data[7:0] = 8'h55;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check($sformatf("t6_ready%0d", k), 32'(req_ready), 32'h1);
            next_cycle();
        end
        @(negedge clock);
        check("t6_busy_inflight", 32'(busy), 32'h1);
        reset = 1'b1;
        @(negedge clock);
        check("t6_rst_busy", 32'(busy), 32'h0);
        check("t6_rst_ready", 32'(req_ready), 32'h0);
        next_cycle();
        reset = 1'b0;
        req_valid = '0;
        for (int k = 0; k < 12; k++) next_cycle();
        @(negedge clock);
        check("t6_no_stale_out", 32'(q_out.size()), 32'd0);
        check("t6_busy_after", 32'(busy), 32'h0);
        next_cycle();

        // 3. Round-robin from pointer 0 with keys cleared by the reset.
        q_out.delete(); q_hs.delete();
        req_data = {8'h3C, 8'h80, 8'h02, 8'h01};
        req_valid = 4'hF;
        for (int k = 0; k < 8; k++) next_cycle();
        req_valid = '0;
        wait_idle("t3_idle");
        check("t3_hs_count", 32'(q_hs.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t3_grant%0d", i),
                  (i < q_hs.size()) ? 32'(q_hs[i].id) : 32'hDEAD_BEEF, 32'(i % 4));
            check($sformatf("t3_grant_cyc%0d", i),
                  (i < q_hs.size()) ? 32'(q_hs[i].cyc - q_hs[0].cyc) : 32'hDEAD_BEEF, 32'(i));
        end
        check("t3_out_count", 32'(q_out.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t3_out_id%0d", i), out_id_at(i), 32'(i % 4));
            check($sformatf("t3_out_data%0d", i), out_data_at(i), 32'(exp_t3[i % 4]));
        end

        // 4. Backpressure: exactly eight beats fit, then drain and resume.
        q_out.delete(); q_hs.delete();
        out_ready = 1'b0;
        hs = 0;
        for (int k = 0; k < 20; k++) begin
            req_valid = 4'b0001;
            req_data[7:0] = 8'h20 + 8'(hs);
            @(negedge clock);
            if (req_valid[0] && req_ready[0]) hs++;
            if (k == 10 || k == 15 || k == 19) begin
                check($sformatf("t4_hold_valid%0d", k), 32'(out_valid), 32'h1);
                check($sformatf("t4_hold_data%0d", k), 32'(out_data), 32'hBF);
                check($sformatf("t4_hold_id%0d", k), 32'(out_id), 32'h0);
            end
            if (k == 19) check("t4_ready_blocked", 32'(req_ready), 32'h0);
            next_cycle();
        end
        check("t4_hs_blocked", 32'(hs), 32'd8);
        out_ready = 1'b1;
        n = 0;
        while (hs < 12 && n < 40) begin
            req_valid = 4'b0001;
            req_data[7:0] = 8'h20 + 8'(hs);
            @(negedge clock);
            if (req_valid[0] && req_ready[0]) hs++;
            next_cycle();
            n++;
        end
        req_valid = '0;
        check("t4_hs_resumed", 32'(hs), 32'd12);
        wait_idle("t4_idle");
        check("t4_out_count", 32'(q_out.size()), 32'd12);
        for (int i = 0; i < 12; i++) begin
            check($sformatf("t4_out_data%0d", i), out_data_at(i), 32'(exp_t4[i]));
            check($sformatf("t4_out_id%0d", i), out_id_at(i), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/enc_pipe_scheduler.md
Name: enc_pipe_scheduler

Overview:
Shares one `encryption` core between R requesters. The core is a 5-stage, non-stallable pipeline, parameterised by N.
- Arbitration is round-robin. Each granted beat is XORed with its requester's own key.
- A tag pipeline tracks each beat's requester ID through the core.
- Results land in an output FIFO. Issue is credit-gated so the FIFO can never overflow, even though the core cannot stall.

Parameters:
N, 8, data/key width; passed to the `encryption` core.
R, 4, number of requesters (2..8).
IDW, 2, requester ID width; equals $clog2(R).
FIFO_DEPTH, 8, output FIFO entries; power of two, at least LATENCY.

Ports:
clock  in  1  rising-edge clock; the only clock.
reset  in  1  synchronous, active-high reset.
req_valid  in  R  per-requester beat valid.
req_data  in  R*N  packed plaintext; requester i uses bits [i*N +: N].
req_ready  out  R  per-requester accept; one-hot or zero.
cfg_we  in  1  key-table write strobe.
cfg_id  in  IDW  key-table write index.
cfg_key  in  N  key-table write value.
out_valid  out  1  FIFO head valid.
out_ready  in  1  consumer accept.
out_data  out  N  encrypted data.
out_id  out  IDW  originating requester.
busy  out  1  1 while any beat is in flight or the FIFO is non-empty.

Behaviour:
- Reset:
  - Synchronous, active-high.
  - Clears: key table (all 0x00), round-robin pointer (0), tag pipe valids, FIFO pointers and count.
  - Outputs after reset: out_valid=0, req_ready=0, busy=0.
  - The core's data registers are not reset. Stale core data is harmless because its tags are invalid.
- Reset mid-operation:
  - All in-flight beats are discarded.
  - No out_valid may assert from pre-reset beats.
- Credit:
  - credit = (fifo_count + inflight) < FIFO_DEPTH.
  - inflight = number of valid tags (0..5).
  - A FIFO pop in the same cycle does not add credit until the next cycle.
- Arbitration:
  - Round-robin starting at pointer p; grant the first i with req_valid[i].
  - req_ready[g] = credit & !reset; all other bits of req_ready are 0.
  - On handshake, p <= g+1 mod R. With no handshake, p holds.
- Issue:
  - On handshake, drive core data = req_data[g] and key = key_table[g] combinationally.
  - Push tag {valid=1, id=g} into a LATENCY=5 shift register.
  - On a non-handshake cycle, push an invalid tag; the core input is don't-care.
- Latency:
  - A beat handshaked in cycle t appears on the core's e_data in cycle t+5, aligned with tag stage 5.
  - It is written into the FIFO at the end of cycle t+5.
  - out_valid is first possible in cycle t+6.
- FIFO:
  - Write {tag.id, e_data} when tag stage 5 is valid.
  - Pop when out_valid & out_ready.
  - Simultaneous push and pop leaves the count unchanged.
  - Overflow is impossible by construction; an assertion must check that a push never occurs while full.
  - out_data/out_id hold stable while out_valid=1 and out_ready=0.
  - Order: results are strictly in handshake order.
- Key table:
  - A cfg write takes effect on the next cycle.
  - A grant in the same cycle as a cfg write to its own ID uses the old key.
- busy = (inflight != 0) | (fifo_count != 0).

Decomposition:
- Package enc_sched_pkg holds:
  - localparam LATENCY=5.
  - Typedef tag_t, packed {valid, id[IDW-1:0]}.
  - Typedef fifo_entry_t {id, data}.
- Sub-module enc_rr_arbiter (req[R], pointer, enable → one-hot grant, grant index).
- The FIFO is inline.
- The core is instantiated as `encryption #(.N(N))`.

Test Plan:
1. Single beat:
   - Stimulus: key0=0x00; req0 data 0x01 handshaked at cycle t; out_ready=1.
   - Required: out_valid in cycle t+6 with out_data=0xFD, out_id=0; busy drops the cycle after the pop.
2. Key effect:
   - Stimulus: key1=0xFF with data 0x00, then key1=0x00 with data 0x00.
   - Required: outputs 0x00 then 0xFF, both with id=1.
3. Round-robin:
   - Stimulus: all 4 requesters continuously valid; out_ready=1.
   - Required: grants 0,1,2,3,0,1…, one per cycle; out_id follows the same order.
4. Backpressure:
   - Stimulus: out_ready=0 while req0 streams.
   - Required: exactly 8 handshakes, then req_ready=0; out_valid holds the first result stable.
   - Then release out_ready: all 8 results drain in order and issue resumes, with no loss or duplication.
5. Config collision:
   - Stimulus: cfg write key2=0xFF in the same cycle req2 (data 0x00, old key 0x00) is granted.
   - Required: result 0xFF; the next req2 beat with data 0x00 gives 0x00.
6. Reset mid-flight:
   - Stimulus: 3 beats issued, then reset asserted for 1 cycle.
   - Required: out_valid never asserts for those beats; busy=0 and req_ready=0 during reset; normal operation resumes with pointer 0.
